mips: RTL and testbench

MIPS -- requirements
Module: mips

---
 rtl/mips.sv | 180 ++++++++++++++++++
 tb/tb_mips.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mips.sv
// Five-stage MIPS subset pipeline (F/D/E/M/W) with branch resolution in D, one delay slot,
// full forwarding and load-use interlocks. External instruction and data memories.
module mips #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] m_data_addr,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_inst_addr,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr
);
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23;

    function automatic logic f_r(input logic [31:0] ins, input logic [5:0] fn);
        return ins[31:26] == OP_R && ins[5:0] == fn;
    endfunction

    function automatic logic f_we(input logic [31:0] ins);
        return f_r(ins, FN_ADDU) || f_r(ins, FN_SUBU) ||
               ins[31:26] inside {OP_ORI, OP_LUI, OP_LW, OP_JAL};
    endfunction

    // Destination is 0 for non-writers, so a 0 match never forwards or stalls.
    function automatic logic [4:0] f_wa(input logic [31:0] ins);
        return !f_we(ins) ? 5'd0 : (ins[31:26] == OP_JAL) ? 5'd31 :
               (ins[31:26] == OP_R) ? ins[15:11] : ins[20:16];
    endfunction

    function automatic logic f_use_rs(input logic [31:0] ins);
        return f_r(ins, FN_ADDU) || f_r(ins, FN_SUBU) || f_r(ins, FN_JR) ||
               ins[31:26] inside {OP_ORI, OP_LW, OP_SW, OP_BEQ};
    endfunction

    function automatic logic f_use_rt(input logic [31:0] ins);
        return f_r(ins, FN_ADDU) || f_r(ins, FN_SUBU) || ins[31:26] inside {OP_SW, OP_BEQ};
    endfunction

    logic [31:0] r_grf [32];
    logic [31:0] r_pc, r_d_pc, r_d_inst;
    logic [31:0] r_e_pc, r_e_inst, r_e_wd;
    logic [31:0] r_e_val [2];
    logic [31:0] r_m_pc, r_m_inst, r_m_wd, r_m_rt;
    logic [31:0] r_w_pc, r_w_inst, r_w_wd;

    logic [4:0]  w_d_src [2];
    logic        w_d_use [2];
    logic [31:0] w_d_val [2];
    logic [4:0]  w_e_src [2];
    logic [31:0] w_e_val [2];
    logic        w_d_beq, w_d_jr, w_d_jmp, w_d_br, w_stall;
    logic [31:0] w_npc, w_e_wd, w_m_rt;
    logic [4:0]  w_e_wa, w_m_wa;
    logic        w_e_lw, w_e_jal, w_m_lw, w_m_sw;

    assign w_d_src[0] = r_d_inst[25:21];
    assign w_d_src[1] = r_d_inst[20:16];
    assign w_d_use[0] = f_use_rs(r_d_inst);
    assign w_d_use[1] = f_use_rt(r_d_inst);
    assign w_e_src[0] = r_e_inst[25:21];
    assign w_e_src[1] = r_e_inst[20:16];
    assign w_d_beq    = r_d_inst[31:26] == OP_BEQ;
    assign w_d_jr     = f_r(r_d_inst, FN_JR);
    assign w_d_jmp    = r_d_inst[31:26] inside {OP_J, OP_JAL};
    assign w_d_br     = w_d_beq || w_d_jr;
    assign w_e_wa     = f_wa(r_e_inst);
    assign w_e_lw     = r_e_inst[31:26] == OP_LW;
    assign w_e_jal    = r_e_inst[31:26] == OP_JAL;
    assign w_m_wa     = f_wa(r_m_inst);
    assign w_m_lw     = r_m_inst[31:26] == OP_LW;
    assign w_m_sw     = r_m_inst[31:26] == OP_SW;

    // D operands: register file, then W, M (non-load), E (jal link), youngest last.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_d_val[k] = r_grf[w_d_src[k]];
            if (w_grf_addr == w_d_src[k]) w_d_val[k] = w_grf_wdata;
            if (!w_m_lw && w_m_wa == w_d_src[k]) w_d_val[k] = r_m_wd;
            if (w_e_jal && w_d_src[k] == 5'd31) w_d_val[k] = r_e_wd;
            if (w_d_src[k] == 5'd0) w_d_val[k] = '0;
        end
    end

    always_comb begin
        w_stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (w_d_use[k] && w_d_src[k] != 5'd0) begin
                if (w_e_wa == w_d_src[k] && (w_e_lw || (w_d_br && !w_e_jal))) w_stall = 1'b1;
                if (w_m_lw && w_m_wa == w_d_src[k] && w_d_br) w_stall = 1'b1;
            end
        end
    end

    always_comb begin
        w_npc = r_pc + 32'd4;
        if (w_d_beq && w_d_val[0] == w_d_val[1])
            w_npc = r_d_pc + 32'd4 + {{14{r_d_inst[15]}}, r_d_inst[15:0], 2'b00};
        if (w_d_jmp) w_npc = {r_d_pc[31:28], r_d_inst[25:0], 2'b00};
        if (w_d_jr) w_npc = w_d_val[0];
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_e_val[k] = r_e_val[k];
            if (w_grf_addr == w_e_src[k]) w_e_val[k] = w_grf_wdata;
            if (!w_m_lw && w_m_wa == w_e_src[k]) w_e_val[k] = r_m_wd;
            if (w_e_src[k] == 5'd0) w_e_val[k] = '0;
        end
    end

    always_comb begin
        w_e_wd = '0;
        case (r_e_inst[31:26])
            OP_R: begin
                if (r_e_inst[5:0] == FN_ADDU) w_e_wd = w_e_val[0] + w_e_val[1];
                else if (r_e_inst[5:0] == FN_SUBU) w_e_wd = w_e_val[0] - w_e_val[1];
            end
            OP_ORI:       w_e_wd = w_e_val[0] | {16'b0, r_e_inst[15:0]};
            OP_LUI:       w_e_wd = {r_e_inst[15:0], 16'b0};
            OP_LW, OP_SW: w_e_wd = w_e_val[0] + {{16{r_e_inst[15]}}, r_e_inst[15:0]};
            OP_JAL:       w_e_wd = r_e_wd;
            default:      w_e_wd = '0;
        endcase
    end

    always_comb begin
        w_m_rt = r_m_rt;
        if (r_m_inst[20:16] != 5'd0 && w_grf_addr == r_m_inst[20:16]) w_m_rt = w_grf_wdata;
    end

    assign i_inst_addr   = r_pc;
    assign m_data_addr   = r_m_wd;
    assign m_data_wdata  = w_m_rt;
    // Gated by reset so an abandoned store cannot land at the reset edge.
    assign m_data_byteen = (w_m_sw && !reset) ? 4'b1111 : 4'b0000;
    assign m_inst_addr   = r_m_pc;
    assign w_grf_we      = f_we(r_w_inst);
    assign w_grf_addr    = f_wa(r_w_inst);
    assign w_grf_wdata   = r_w_wd;
    assign w_inst_addr   = r_w_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
            {r_d_pc, r_d_inst, r_e_pc, r_e_inst, r_e_wd} <= '0;
            r_e_val[0] <= '0;
            r_e_val[1] <= '0;
            {r_m_pc, r_m_inst, r_m_wd, r_m_rt, r_w_pc, r_w_inst, r_w_wd} <= '0;
            for (int i = 0; i < 32; i++) r_grf[i] <= '0;
        end else begin
            if (!w_stall) begin
                r_pc     <= w_npc;
                r_d_pc   <= r_pc;
                r_d_inst <= i_inst_rdata;
            end
            r_e_pc     <= w_stall ? 32'd0 : r_d_pc;
            r_e_inst   <= w_stall ? 32'd0 : r_d_inst;
            r_e_wd     <= w_stall ? 32'd0 : r_d_pc + 32'd8;
            r_e_val[0] <= w_stall ? 32'd0 : w_d_val[0];
            r_e_val[1] <= w_stall ? 32'd0 : w_d_val[1];
            r_m_pc     <= r_e_pc;
            r_m_inst   <= r_e_inst;
            r_m_wd     <= w_e_wd;
            r_m_rt     <= w_e_val[1];
            r_w_pc     <= r_m_pc;
            r_w_inst   <= r_m_inst;
            r_w_wd     <= w_m_lw ? m_data_rdata : r_m_wd;
            if (w_grf_we && w_grf_addr != 5'd0) r_grf[w_grf_addr] <= w_grf_wdata;
        end
    end
endmodule

// File: tb/tb_mips.sv
// Directed-program bench for mips: small instruction/data memories, write-back and store
// logs sampled on the falling edge, hand-computed expectations.
module tb_mips;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] i_inst_addr, i_inst_rdata;
    logic [31:0] m_data_addr, m_data_rdata, m_data_wdata, m_inst_addr;
    logic [3:0]  m_data_byteen;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;
    logic [31:0] w_grf_wdata, w_inst_addr;

    mips dut (
        .clk          (clk),
        .reset        (reset),
        .i_inst_addr  (i_inst_addr),
        .i_inst_rdata (i_inst_rdata),
        .m_data_addr  (m_data_addr),
        .m_data_rdata (m_data_rdata),
        .m_data_wdata (m_data_wdata),
        .m_data_byteen(m_data_byteen),
        .m_inst_addr  (m_inst_addr),
        .w_grf_we     (w_grf_we),
        .w_grf_addr   (w_grf_addr),
        .w_grf_wdata  (w_grf_wdata),
        .w_inst_addr  (w_inst_addr)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    assign i_inst_rdata = (i_inst_addr[31:8] == 24'h000030) ? imem[i_inst_addr[7:2]] : 32'h0;
    assign m_data_rdata = dmem[m_data_addr[7:2]];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (m_data_byteen[b]) dmem[m_data_addr[7:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
    end

    typedef struct { logic [31:0] pc; logic [4:0] a; logic [31:0] d; int cyc; } wev_t;
    typedef struct { logic [31:0] pc; logic [31:0] a; logic [31:0] d; logic [3:0] be; } sev_t;
    wev_t        wq [$];
    sev_t        sq [$];
    logic [31:0] fq [$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(negedge clk) begin
        wev_t we_;
        sev_t se_;
        cyc++;
        if (!reset) begin
            fq.push_back(i_inst_addr);
            if (w_grf_we) begin
                we_.pc = w_inst_addr; we_.a = w_grf_addr; we_.d = w_grf_wdata; we_.cyc = cyc;
                wq.push_back(we_);
            end
            if (m_data_byteen != 4'b0) begin
                se_.pc = m_inst_addr; se_.a = m_data_addr; se_.d = m_data_wdata;
                se_.be = m_data_byteen;
                sq.push_back(se_);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic wev_t wget(input int i);
        wev_t e;
        e.pc = 32'hdeadbeef; e.a = 5'h1f; e.d = 32'hdeadbeef; e.cyc = -1000;
        if (i < wq.size()) e = wq[i];
        return e;
    endfunction

    function automatic logic [31:0] fget(input int i);
        return (i < fq.size()) ? fq[i] : 32'hdeadbeef;
    endfunction

    task automatic check_w(input string tag, input int i, input logic [31:0] pc,
                           input logic [4:0] a, input logic [31:0] d);
        wev_t e = wget(i);
        check_eq({tag, "_pc"}, e.pc, pc);
        check_eq({tag, "_addr"}, {27'b0, e.a}, {27'b0, a});
        check_eq({tag, "_data"}, e.d, d);
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'h0;
            dmem[i] = 32'h0;
        end
    endtask

    // Two reset edges, check the reset-state outputs, then release.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq({tag, "_rst_pc"}, i_inst_addr, 32'h3000);
        check_eq({tag, "_rst_be"}, {28'b0, m_data_byteen}, 32'h0);
        check_eq({tag, "_rst_we"}, {31'b0, w_grf_we}, 32'h0);
        check_eq({tag, "_rst_wa"}, {27'b0, w_grf_addr}, 32'h0);
        check_eq({tag, "_rst_wd"}, w_grf_wdata, 32'h0);
        check_eq({tag, "_rst_mpc"}, m_inst_addr, 32'h0);
        check_eq({tag, "_rst_wpc"}, w_inst_addr, 32'h0);
        wq.delete();
        sq.delete();
        fq.delete();
        reset = 1'b0;
    endtask

    task automatic run_prog(input string tag);
        do_reset(tag);
        repeat (30) @(negedge clk);
    endtask

    initial begin
        // A: ALU forwarding and $0 writes
        clear_mem();
        imem[0] = 32'h34011234;  // ori  $1,$0,0x1234
        imem[1] = 32'h00211021;  // addu $2,$1,$1
        imem[2] = 32'h34000005;  // ori  $0,$0,5
        imem[3] = 32'h00003021;  // addu $6,$0,$0
        run_prog("A");
        check_eq("A_fetch0", fget(0), 32'h3000);
        check_eq("A_fetch1", fget(1), 32'h3004);
        check_eq("A_fetch2", fget(2), 32'h3008);
        check_eq("A_wcount", wq.size(), 32'd4);
        check_w("A_w0", 0, 32'h3000, 5'd1, 32'h00001234);
        check_w("A_w1", 1, 32'h3004, 5'd2, 32'h00002468);
        check_w("A_w2", 2, 32'h3008, 5'd0, 32'h00000005);
        check_w("A_w3", 3, 32'h300C, 5'd6, 32'h00000000);
        check_eq("A_gap01", wget(1).cyc - wget(0).cyc, 32'd1);

        // B: store, load, load-use stall
        clear_mem();
        imem[0] = 32'h3C038000;  // lui  $3,0x8000
        imem[1] = 32'hAC030008;  // sw   $3,8($0)
        imem[2] = 32'h8C040008;  // lw   $4,8($0)
        imem[3] = 32'h00842821;  // addu $5,$4,$4
        run_prog("B");
        check_eq("B_scount", sq.size(), 32'd1);
        if (sq.size() > 0) begin
            check_eq("B_s_addr", sq[0].a, 32'h8);
            check_eq("B_s_data", sq[0].d, 32'h80000000);
            check_eq("B_s_be", {28'b0, sq[0].be}, 32'hF);
            check_eq("B_s_pc", sq[0].pc, 32'h3004);
        end
        check_eq("B_wcount", wq.size(), 32'd3);
        check_w("B_w0", 0, 32'h3000, 5'd3, 32'h80000000);
        check_w("B_w1", 1, 32'h3008, 5'd4, 32'h80000000);
        check_w("B_w2", 2, 32'h300C, 5'd5, 32'h00000000);
        check_eq("B_gap_lui_lw", wget(1).cyc - wget(0).cyc, 32'd2);
        check_eq("B_gap_lw_addu", wget(2).cyc - wget(1).cyc, 32'd2);

        // C: taken beq with delay slot
        clear_mem();
        imem[0] = 32'h10000002;  // beq $0,$0,+2
        imem[1] = 32'h34070077;  // ori $7,$0,0x77
        imem[2] = 32'h34080088;  // ori $8,$0,0x88 (skipped)
        imem[3] = 32'h34090099;  // ori $9,$0,0x99
        run_prog("C");
        check_eq("C_fetch2", fget(2), 32'h300C);
        check_eq("C_wcount", wq.size(), 32'd2);
        check_w("C_w0", 0, 32'h3004, 5'd7, 32'h77);
        check_w("C_w1", 1, 32'h300C, 5'd9, 32'h99);

        // D: jal / jr round trip
        clear_mem();
        imem[4]  = 32'h0C000C10;  // jal 0x3040
        imem[6]  = 32'h340A00AA;  // ori $10,$0,0xAA
        imem[7]  = 32'h1000FFFF;  // beq $0,$0,-1 (park)
        imem[16] = 32'h03E00008;  // jr  $31
        run_prog("D");
        check_eq("D_fetch6", fget(6), 32'h3040);
        check_eq("D_fetch8", fget(8), 32'h3018);
        check_eq("D_wcount", wq.size(), 32'd2);
        check_w("D_w0", 0, 32'h3010, 5'd31, 32'h3018);
        check_w("D_w1", 1, 32'h3018, 5'd10, 32'hAA);

        // E: reset while a store is in M
        clear_mem();
        imem[0] = 32'h34010055;  // ori $1,$0,0x55
        imem[1] = 32'hAC010010;  // sw  $1,16($0)
        do_reset("E");
        for (int i = 0; i < 20 && m_inst_addr !== 32'h3004; i++) @(negedge clk);
        check_eq("E_sw_in_m", m_inst_addr, 32'h3004);
        reset = 1'b1;
        #1 check_eq("E_be_gated", {28'b0, m_data_byteen}, 32'h0);
        @(posedge clk);
        #1;
        check_eq("E_no_write", dmem[4], 32'h0);
        check_eq("E_mpc_clr", m_inst_addr, 32'h0);
        check_eq("E_pc_rst", i_inst_addr, 32'h3000);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
